// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
//    Shared definitions for the 5-stage pipeline sequencing controller:
//    forwarding select encodings, the controller FSM state type and the
//    hard-wired zero register number.
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

   // ALU operand source selects driven towards the EX-stage operand muxes
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // $0 always reads as zero, so it is never a forwarding or hazard source
   localparam logic [4:0] REG_ZERO = 5'd0;

   // RUN: normal flow, LU: still inserting load-use bubbles
   typedef enum logic {
      ST_RUN = 1'b0,
      ST_LU  = 1'b1
   } state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
//    Purely combinational forwarding comparator for one source operand.
//    Decides whether the operand should come from the register file, from
//    the MEM-stage ALU result or from the WB-stage write data.
//
//    Ports:
//       exSrc_i        source register number of the consuming instruction
//       memWreg_i      destination register of the instruction in MEM
//       memRegWrite_i  MEM instruction writes the register file
//       wbWreg_i       destination register of the instruction in WB
//       wbRegWrite_i   WB instruction writes the register file
//       sel_o          operand select (FWD_RF / FWD_WB / FWD_MEM)
// ---------------------------------------------------------------------------
module fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] exSrc_i,
   input  logic [4:0] memWreg_i,
   input  logic       memRegWrite_i,
   input  logic [4:0] wbWreg_i,
   input  logic       wbRegWrite_i,
   output logic [1:0] sel_o
);

   // MEM holds the younger result, so it wins over WB when both match
   always_comb begin
      sel_o = FWD_RF;
      if (memRegWrite_i && (memWreg_i != REG_ZERO) && (memWreg_i == exSrc_i)) begin
         sel_o = FWD_MEM;
      end else if (wbRegWrite_i && (wbWreg_i != REG_ZERO) && (wbWreg_i == exSrc_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//    Pipeline sequencing controller for the IF/ID/EX/MEM/WB core. Produces
//    EX-stage forwarding selects, stalls/flushes the pipeline registers on
//    load-use hazards, taken branches and memory-busy, and keeps saturating
//    stall/flush event counters for performance debug.
//
//    Parameters:
//       LU_CYC  bubble cycles per load-use hazard (1..3)
//       CNT_W   width of each event counter
//
//    Ports:
//       clk, rst                 clock, asynchronous active-low reset
//       ID_rs/ID_rt/ID_uses_rt   source fields of the instruction in ID
//       EX_rs/EX_rt/EX_MemRead/EX_wreg  instruction in EX
//       MEM_wreg/MEM_RegWrite    instruction in MEM
//       WB_wreg/WB_RegWrite      instruction in WB
//       br_taken, mem_busy       branch resolved taken in MEM, memory stall
//       *_we, *_flush            pipeline register enables / NOP inserts
//       fwd_a, fwd_b             ALU operand forwarding selects
//       stall_cnt, flush_cnt     saturating event counters
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int LU_CYC = 1,
   parameter int CNT_W  = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_uses_rt,
   input  logic [4:0]       EX_rs,
   input  logic [4:0]       EX_rt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_wreg,
   input  logic [4:0]       MEM_wreg,
   input  logic             MEM_RegWrite,
   input  logic [4:0]       WB_wreg,
   input  logic             WB_RegWrite,
   input  logic             br_taken,
   input  logic             mem_busy,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   generate
      if ((LU_CYC < 1) || (LU_CYC > 3)) begin : g_badLuCyc
         $error("hazard_ctrl: LU_CYC must be in 1..3");
      end
   endgenerate

   // Bubbles still owed after the first one, loaded when entering LU
   localparam logic [1:0]       BCNT_INIT = 2'(LU_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e           state_q, state_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

   logic       loadUse;
   logic       busyEvent;
   logic       stallEvent;
   logic [1:0] fwdASel;
   logic [1:0] fwdBSel;

   fwd_unit u_fwdA (
      .exSrc_i       (EX_rs),
      .memWreg_i     (MEM_wreg),
      .memRegWrite_i (MEM_RegWrite),
      .wbWreg_i      (WB_wreg),
      .wbRegWrite_i  (WB_RegWrite),
      .sel_o         (fwdASel)
   );

   fwd_unit u_fwdB (
      .exSrc_i       (EX_rt),
      .memWreg_i     (MEM_wreg),
      .memRegWrite_i (MEM_RegWrite),
      .wbWreg_i      (WB_wreg),
      .wbRegWrite_i  (WB_RegWrite),
      .sel_o         (fwdBSel)
   );

   // Forwarding is parked on the register file while reset is held
   assign fwd_a = rst ? fwdASel : FWD_RF;
   assign fwd_b = rst ? fwdBSel : FWD_RF;

   assign loadUse = EX_MemRead && (EX_wreg != REG_ZERO) &&
                    ((EX_wreg == ID_rs) || (ID_uses_rt && (EX_wreg == ID_rt)));

   // Event priority: branch beats memory-busy beats load-use. In LU the
   // EX stage already holds a bubble, so loadUse is not consulted there.
   assign busyEvent  = !br_taken && mem_busy;
   assign stallEvent = !br_taken && !mem_busy &&
                       ((state_q == ST_LU) || loadUse);

   // State, bubble counter and event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         bcnt_q     <= '0;
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   // Next state; a busy memory freezes everything, a branch squashes any
   // bubbles still owed because the stalled instructions are discarded
   always_comb begin
      state_d    = state_q;
      bcnt_d     = bcnt_q;
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if (br_taken) begin
         state_d = ST_RUN;
         bcnt_d  = '0;
         if (!(&flushCnt_q)) begin
            flushCnt_d = flushCnt_q + CNT_ONE;
         end
      end else if (!mem_busy) begin
         if (stallEvent && !(&stallCnt_q)) begin
            stallCnt_d = stallCnt_q + CNT_ONE;
         end
         unique case (state_q)
            ST_RUN: begin
               if (loadUse && (LU_CYC > 1)) begin
                  state_d = ST_LU;
                  bcnt_d  = BCNT_INIT;
               end
            end
            ST_LU: begin
               if (bcnt_q == 2'd1) begin
                  state_d = ST_RUN;
                  bcnt_d  = '0;
               end else begin
                  bcnt_d = bcnt_q - 2'd1;
               end
            end
         endcase
      end
   end

   // Pipeline register controls; a bubble holds PC and IF/ID and turns
   // the ID/EX load into a NOP while the older stages keep draining
   always_comb begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      id_ex_we     = 1'b1;
      ex_mem_we    = 1'b1;
      mem_wb_we    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      if (!rst) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_we     = 1'b0;
         ex_mem_we    = 1'b0;
         mem_wb_we    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (br_taken) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (busyEvent) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         mem_wb_we = 1'b0;
      end else if (stallEvent) begin
         pc_we       = 1'b0;
         if_id_we    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   assign stall_cnt = stallCnt_q;
   assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//    Three controllers share one set of inputs: LU_CYC=1/CNT_W=16,
//    LU_CYC=3/CNT_W=16 and LU_CYC=3/CNT_W=2. A reference model tracks the
//    number of bubbles still owed and the event counts per instance.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   // {pc,if_id,id_ex,ex_mem,mem_wb we, if_id,id_ex,ex_mem flush}
   localparam logic [7:0] CTL_RUN   = 8'b11111_000;
   localparam logic [7:0] CTL_STALL = 8'b00111_010;
   localparam logic [7:0] CTL_BUSY  = 8'b00000_000;
   localparam logic [7:0] CTL_BR    = 8'b11111_111;
   localparam logic [7:0] CTL_RST   = 8'b00000_111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] ID_rs, ID_rt, EX_rs, EX_rt, EX_wreg, MEM_wreg, WB_wreg;
   logic       ID_uses_rt, EX_MemRead, MEM_RegWrite, WB_RegWrite;
   logic       br_taken, mem_busy;

   logic [4:0]  we0, we1, we2;
   logic [2:0]  fl0, fl1, fl2;
   logic [1:0]  fa0, fa1, fa2, fb0, fb1, fb2;
   logic [15:0] sc0, sc1, fc0, fc1;
   logic [1:0]  sc2, fc2;

   int total = 0;
   int bad   = 0;

   // Reference model state: bubbles still owed and event counts
   int owed[3];
   int mSc[3];
   int mFc[3];

   always #5 clk = ~clk;

   hazard_ctrl #(.LU_CYC(1), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
      .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead), .EX_wreg(EX_wreg),
      .MEM_wreg(MEM_wreg), .MEM_RegWrite(MEM_RegWrite), .WB_wreg(WB_wreg),
      .WB_RegWrite(WB_RegWrite), .br_taken(br_taken), .mem_busy(mem_busy),
      .pc_we(we0[4]), .if_id_we(we0[3]), .id_ex_we(we0[2]), .ex_mem_we(we0[1]),
      .mem_wb_we(we0[0]), .if_id_flush(fl0[2]), .id_ex_flush(fl0[1]),
      .ex_mem_flush(fl0[0]), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0)
   );

   hazard_ctrl #(.LU_CYC(3), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
      .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead), .EX_wreg(EX_wreg),
      .MEM_wreg(MEM_wreg), .MEM_RegWrite(MEM_RegWrite), .WB_wreg(WB_wreg),
      .WB_RegWrite(WB_RegWrite), .br_taken(br_taken), .mem_busy(mem_busy),
      .pc_we(we1[4]), .if_id_we(we1[3]), .id_ex_we(we1[2]), .ex_mem_we(we1[1]),
      .mem_wb_we(we1[0]), .if_id_flush(fl1[2]), .id_ex_flush(fl1[1]),
      .ex_mem_flush(fl1[0]), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1)
   );

   hazard_ctrl #(.LU_CYC(3), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
      .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead), .EX_wreg(EX_wreg),
      .MEM_wreg(MEM_wreg), .MEM_RegWrite(MEM_RegWrite), .WB_wreg(WB_wreg),
      .WB_RegWrite(WB_RegWrite), .br_taken(br_taken), .mem_busy(mem_busy),
      .pc_we(we2[4]), .if_id_we(we2[3]), .id_ex_we(we2[2]), .ex_mem_we(we2[1]),
      .mem_wb_we(we2[0]), .if_id_flush(fl2[2]), .id_ex_flush(fl2[1]),
      .ex_mem_flush(fl2[0]), .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(sc2), .flush_cnt(fc2)
   );

   // Accessors so loops can walk the three instances
   function automatic logic [7:0] getCtl(int i);
      case (i)
         0:       return {we0, fl0};
         1:       return {we1, fl1};
         default: return {we2, fl2};
      endcase
   endfunction

   function automatic logic [1:0] getFa(int i);
      case (i)
         0:       return fa0;
         1:       return fa1;
         default: return fa2;
      endcase
   endfunction

   function automatic logic [1:0] getFb(int i);
      case (i)
         0:       return fb0;
         1:       return fb1;
         default: return fb2;
      endcase
   endfunction

   function automatic int getSc(int i);
      case (i)
         0:       return int'(sc0);
         1:       return int'(sc1);
         default: return int'(sc2);
      endcase
   endfunction

   function automatic int getFc(int i);
      case (i)
         0:       return int'(fc0);
         1:       return int'(fc1);
         default: return int'(fc2);
      endcase
   endfunction

   function automatic int lucOf(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int cmaxOf(int i);
      return (i == 2) ? 3 : 65535;
   endfunction

   // A loaded register that ID wants to read right now
   function automatic bit luNow();
      return EX_MemRead && (EX_wreg != 0) &&
             ((EX_wreg == ID_rs) || (ID_uses_rt && (EX_wreg == ID_rt)));
   endfunction

   // Expected pipeline controls from the owed-bubble count and current inputs
   function automatic logic [7:0] expCtl(int i);
      if (!rst)                    return CTL_RST;
      if (br_taken)                return CTL_BR;
      if (mem_busy)                return CTL_BUSY;
      if (owed[i] > 0 || luNow())  return CTL_STALL;
      return CTL_RUN;
   endfunction

   // Youngest matching writer wins; $0 is never a source
   function automatic logic [1:0] expFwd(logic [4:0] src);
      if (!rst) return 2'b00;
      if (MEM_RegWrite && MEM_wreg != 0 && MEM_wreg == src) return 2'b10;
      if (WB_RegWrite && WB_wreg != 0 && WB_wreg == src)    return 2'b01;
      return 2'b00;
   endfunction

   // Move the model across one rising edge using the inputs present at it
   task automatic modelEdge();
      for (int i = 0; i < 3; i++) begin
         if (!rst) continue;
         if (br_taken) begin
            owed[i] = 0;
            if (mFc[i] < cmaxOf(i)) mFc[i]++;
         end else if (mem_busy) begin
         end else if (owed[i] > 0) begin
            owed[i]--;
            if (mSc[i] < cmaxOf(i)) mSc[i]++;
         end else if (luNow()) begin
            owed[i] = lucOf(i) - 1;
            if (mSc[i] < cmaxOf(i)) mSc[i]++;
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic idleInputs();
      ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0;
      EX_rs = 5'd0; EX_rt = 5'd0; EX_MemRead = 1'b0; EX_wreg = 5'd0;
      MEM_wreg = 5'd0; MEM_RegWrite = 1'b0; WB_wreg = 5'd0; WB_RegWrite = 1'b0;
      br_taken = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic modelClear();
      for (int i = 0; i < 3; i++) begin
         owed[i] = 0; mSc[i] = 0; mFc[i] = 0;
      end
   endtask

   // Hold reset across one edge, release just after it
   task automatic applyStimulusReset();
      rst = 1'b0;
      idleInputs();
      modelClear();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Load-use on rt: EX loads $5, ID reads $5 through rt
   task automatic driveLoadUse();
      EX_MemRead = 1'b1; EX_wreg = 5'd5; ID_rt = 5'd5; ID_uses_rt = 1'b1; ID_rs = 5'd2;
   endtask

   // Reset values visible while reset is held, even with matching fwd inputs
   task automatic test_reset();
      rst = 1'b0;
      idleInputs();
      modelClear();
      EX_rs = 5'd3; EX_rt = 5'd3; MEM_wreg = 5'd3; MEM_RegWrite = 1'b1;
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (getCtl(i) !== CTL_RST) begin
            bad++; $display("[TB] FAIL reset_ctl dut%0d: got %b want %b", i, getCtl(i), CTL_RST);
         end
         total++;
         if (getFa(i) !== 2'b00 || getFb(i) !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_fwd dut%0d: got %b/%b want 00/00", i, getFa(i), getFb(i));
         end
         total++;
         if (getSc(i) !== 0 || getFc(i) !== 0) begin
            bad++; $display("[TB] FAIL reset_cnt dut%0d: got %0d/%0d want 0/0", i, getSc(i), getFc(i));
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      idleInputs();
   endtask

   // Directed forwarding patterns with spelled-out expected selects
   task automatic test_forwarding();
      logic [4:0] rs, rt, mw, ww;
      logic       mrw, wrw;
      logic [1:0] ea, eb;
      applyStimulusReset();
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: begin rs = 3; rt = 7; mw = 3; mrw = 1; ww = 3; wrw = 1; ea = 2'b10; eb = 2'b00; end
            1: begin rs = 3; rt = 3; mw = 3; mrw = 0; ww = 3; wrw = 1; ea = 2'b01; eb = 2'b01; end
            2: begin rs = 0; rt = 5; mw = 0; mrw = 1; ww = 5; wrw = 1; ea = 2'b00; eb = 2'b01; end
            3: begin rs = 9; rt = 9; mw = 9; mrw = 1; ww = 0; wrw = 1; ea = 2'b10; eb = 2'b10; end
            default: begin rs = 0; rt = 0; mw = 0; mrw = 1; ww = 0; wrw = 1; ea = 2'b00; eb = 2'b00; end
         endcase
         EX_rs = rs; EX_rt = rt; MEM_wreg = mw; MEM_RegWrite = mrw;
         WB_wreg = ww; WB_RegWrite = wrw;
         #2;
         for (int i = 0; i < 3; i++) begin
            total++;
            if (getFa(i) !== ea || getFb(i) !== eb) begin
               bad++; $display("[TB] FAIL fwd_pat%0d dut%0d: got %b/%b want %b/%b",
                               k, i, getFa(i), getFb(i), ea, eb);
            end
         end
      end
      idleInputs();
      advance();
   endtask

   // Single-bubble controller: one stall, then no stall without a real match
   task automatic test_load_use_single();
      applyStimulusReset();
      driveLoadUse();
      #4;
      total++;
      if (getCtl(0) !== CTL_STALL) begin
         bad++; $display("[TB] FAIL lu1_stall: got %b want %b", getCtl(0), CTL_STALL);
      end
      advance();
      EX_MemRead = 1'b0;
      #4;
      total++;
      if (getCtl(0) !== CTL_RUN || getSc(0) !== 1) begin
         bad++; $display("[TB] FAIL lu1_after: got %b cnt %0d want %b cnt 1", getCtl(0), getSc(0), CTL_RUN);
      end
      advance();
      applyStimulusReset();
      driveLoadUse();
      ID_uses_rt = 1'b0; ID_rs = 5'd6;
      #4;
      total++;
      if (getCtl(0) !== CTL_RUN) begin
         bad++; $display("[TB] FAIL lu1_norst: got %b want %b", getCtl(0), CTL_RUN);
      end
      advance();
      total++;
      if (getSc(0) !== 0) begin
         bad++; $display("[TB] FAIL lu1_nocnt: got %0d want 0", getSc(0));
      end
      idleInputs();
   endtask

   // Three-bubble controller: exactly three stalls, then normal flow
   task automatic test_load_use_multi();
      applyStimulusReset();
      driveLoadUse();
      for (int c = 0; c < 3; c++) begin
         if (c == 1) EX_MemRead = 1'b0;
         #4;
         total++;
         if (getCtl(1) !== CTL_STALL) begin
            bad++; $display("[TB] FAIL lu3_stall%0d: got %b want %b", c, getCtl(1), CTL_STALL);
         end
         advance();
      end
      #4;
      total++;
      if (getCtl(1) !== CTL_RUN || getSc(1) !== 3) begin
         bad++; $display("[TB] FAIL lu3_end: got %b cnt %0d want %b cnt 3", getCtl(1), getSc(1), CTL_RUN);
      end
      advance();
      idleInputs();
   endtask

   // Taken branch (with busy) in the second bubble cancels the rest
   task automatic test_branch_in_lu();
      applyStimulusReset();
      driveLoadUse();
      advance();
      EX_MemRead = 1'b0; br_taken = 1'b1; mem_busy = 1'b1;
      #4;
      total++;
      if (getCtl(1) !== CTL_BR) begin
         bad++; $display("[TB] FAIL br_lu_ctl: got %b want %b", getCtl(1), CTL_BR);
      end
      advance();
      br_taken = 1'b0; mem_busy = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #4;
         total++;
         if (getCtl(1) !== CTL_RUN || getFc(1) !== 1 || getSc(1) !== 1) begin
            bad++; $display("[TB] FAIL br_lu_after%0d: got %b fc %0d sc %0d want %b fc 1 sc 1",
                            c, getCtl(1), getFc(1), getSc(1), CTL_RUN);
         end
         advance();
      end
   endtask

   // Memory-busy freezes the bubble sequence; the owed bubbles resume after
   task automatic test_busy_in_lu();
      applyStimulusReset();
      driveLoadUse();
      advance();
      EX_MemRead = 1'b0; mem_busy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #4;
         total++;
         if (getCtl(1) !== CTL_BUSY || getSc(1) !== 1) begin
            bad++; $display("[TB] FAIL busy_lu%0d: got %b sc %0d want %b sc 1", c, getCtl(1), getSc(1), CTL_BUSY);
         end
         advance();
      end
      mem_busy = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #4;
         total++;
         if (getCtl(1) !== CTL_STALL) begin
            bad++; $display("[TB] FAIL busy_resume%0d: got %b want %b", c, getCtl(1), CTL_STALL);
         end
         advance();
      end
      #4;
      total++;
      if (getCtl(1) !== CTL_RUN || getSc(1) !== 3) begin
         bad++; $display("[TB] FAIL busy_end: got %b sc %0d want %b sc 3", getCtl(1), getSc(1), CTL_RUN);
      end
      advance();
   endtask

   // Reset dropped mid-cycle in LU acts immediately and leaves no bubble
   task automatic test_reset_mid_lu();
      applyStimulusReset();
      driveLoadUse();
      EX_rs = 5'd4; MEM_wreg = 5'd4; MEM_RegWrite = 1'b1;
      advance();
      EX_MemRead = 1'b0;
      #2;
      rst = 1'b0;
      modelClear();
      #1;
      total++;
      if (getCtl(1) !== CTL_RST || getSc(1) !== 0 || getFa(1) !== 2'b00) begin
         bad++; $display("[TB] FAIL rst_mid: got %b sc %0d fa %b want %b sc 0 fa 00",
                         getCtl(1), getSc(1), getFa(1), CTL_RST);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      idleInputs();
      for (int c = 0; c < 2; c++) begin
         #4;
         total++;
         if (getCtl(1) !== CTL_RUN) begin
            bad++; $display("[TB] FAIL rst_mid_after%0d: got %b want %b", c, getCtl(1), CTL_RUN);
         end
         advance();
      end
   endtask

   // Counters stick at all-ones on the 2-bit instance
   task automatic test_saturation();
      applyStimulusReset();
      br_taken = 1'b1;
      for (int c = 0; c < 5; c++) advance();
      br_taken = 1'b0;
      #4;
      total++;
      if (getFc(2) !== 3 || getFc(0) !== 5) begin
         bad++; $display("[TB] FAIL sat_flush: got %0d/%0d want 3/5", getFc(2), getFc(0));
      end
      advance();
      for (int r = 0; r < 2; r++) begin
         driveLoadUse();
         advance();
         EX_MemRead = 1'b0;
         advance();
         advance();
      end
      #4;
      total++;
      if (getSc(2) !== 3 || getSc(1) !== 6 || getSc(0) !== 2) begin
         bad++; $display("[TB] FAIL sat_stall: got %0d/%0d/%0d want 3/6/2", getSc(2), getSc(1), getSc(0));
      end
      advance();
      idleInputs();
   endtask

   // Random traffic on a small register set against the model, every cycle
   task automatic test_random();
      applyStimulusReset();
      for (int c = 0; c < 400; c++) begin
         ID_rs = 5'($urandom_range(0, 3));   ID_rt = 5'($urandom_range(0, 3));
         ID_uses_rt = 1'($urandom_range(0, 1));
         EX_rs = 5'($urandom_range(0, 3));   EX_rt = 5'($urandom_range(0, 3));
         EX_MemRead = ($urandom_range(0, 2) == 0);
         EX_wreg = 5'($urandom_range(0, 3));
         MEM_wreg = 5'($urandom_range(0, 3)); MEM_RegWrite = 1'($urandom_range(0, 1));
         WB_wreg = 5'($urandom_range(0, 3));  WB_RegWrite = 1'($urandom_range(0, 1));
         br_taken = ($urandom_range(0, 9) == 0);
         mem_busy = ($urandom_range(0, 5) == 0);
         #4;
         for (int i = 0; i < 3; i++) begin
            total++;
            if (getCtl(i) !== expCtl(i)) begin
               bad++; $display("[TB] FAIL rnd_ctl c%0d dut%0d: got %b want %b", c, i, getCtl(i), expCtl(i));
            end
            total++;
            if (getFa(i) !== expFwd(EX_rs) || getFb(i) !== expFwd(EX_rt)) begin
               bad++; $display("[TB] FAIL rnd_fwd c%0d dut%0d: got %b/%b want %b/%b",
                               c, i, getFa(i), getFb(i), expFwd(EX_rs), expFwd(EX_rt));
            end
            total++;
            if (getSc(i) !== mSc[i] || getFc(i) !== mFc[i]) begin
               bad++; $display("[TB] FAIL rnd_cnt c%0d dut%0d: got %0d/%0d want %0d/%0d",
                               c, i, getSc(i), getFc(i), mSc[i], mFc[i]);
            end
         end
         advance();
      end
      idleInputs();
   endtask

   // Scenario sequence, then the one summary line
   initial begin
      idleInputs();
      test_reset();
      test_forwarding();
      test_load_use_single();
      test_load_use_multi();
      test_branch_in_lu();
      test_busy_in_lu();
      test_reset_mid_lu();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
